// File: rtl/opt1_drain.sv
// Column drain for a carry-save MAC array: captures per-row sum/carry, clears the MACs,
// then streams the resolved results row by row over a valid/ready handshake.
// Optional saturation of each result is enabled by defining OPT1_DRAIN_SAT_EN.
module opt1_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int ROWS      = 4,
  parameter int SAT_WIDTH = 16,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROWS*ACC_WIDTH-1:0] in_sum,
  input  logic [ROWS*ACC_WIDTH-1:0] in_carry,
  output logic                      clc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [RW-1:0]             out_row,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

`ifdef OPT1_DRAIN_SAT_EN
  // Signed clamp bounds, already sign-extended to the accumulator width.
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-SAT_WIDTH+1){1'b0}}, {(SAT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   buf_sum_q   [ROWS];
  logic [ACC_WIDTH-1:0]   buf_sum_d   [ROWS];
  logic [ACC_WIDTH-1:0]   buf_carry_q [ROWS];
  logic [ACC_WIDTH-1:0]   buf_carry_d [ROWS];
  logic [RW-1:0]          row_q, row_d;
  logic                   clc_q, clc_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [RW-1:0]          next_row;

  function automatic logic [ACC_WIDTH-1:0] resolve(input logic [ACC_WIDTH-1:0] s,
                                                   input logic [ACC_WIDTH-1:0] c);
    logic [ACC_WIDTH-1:0] raw;
    raw = s + c;
`ifdef OPT1_DRAIN_SAT_EN
    if ($signed(raw) > $signed(SAT_MAX)) return SAT_MAX;
    if ($signed(raw) < $signed(SAT_MIN)) return SAT_MIN;
`endif
    return raw;
  endfunction

  assign next_row = row_q + RW'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    buf_sum_d   = buf_sum_q;
    buf_carry_d = buf_carry_q;
    row_d       = row_q;
    clc_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int r = 0; r < ROWS; r++) begin
            buf_sum_d[r]   = in_sum[r*ACC_WIDTH +: ACC_WIDTH];
            buf_carry_d[r] = in_carry[r*ACC_WIDTH +: ACC_WIDTH];
          end
          clc_d   = 1'b1;
          row_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = resolve(buf_sum_q[0], buf_carry_q[0]);
        row_d       = '0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          if (row_q == LAST_ROW) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            row_d      = next_row;
            out_data_d = resolve(buf_sum_q[next_row], buf_carry_q[next_row]);
            out_last_d = (next_row == LAST_ROW);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the capture buffers are reset too, so a reset leaves no stale column data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      clc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        buf_sum_q[r]   <= '0;
        buf_carry_q[r] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      clc_q       <= clc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      buf_sum_q   <= buf_sum_d;
      buf_carry_q <= buf_carry_d;
    end
  end

  assign clc       = clc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_opt1_drain.sv
// Directed bench for opt1_drain (ROWS=4, ACC_WIDTH=32): latency, streaming, stalls,
// wrap/saturation, start during a drain, and reset mid-drain.
module tb_opt1_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] in_sum;
  logic [127:0] in_carry;
  logic         clc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_row;
  logic         out_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sums   [4];
  logic [31:0] carries[4];
  logic [31:0] exp_d  [4];

  opt1_drain #(.ACC_WIDTH(32), .ROWS(4), .SAT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .clc      (clc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] s0, s1, s2, s3,
                         input logic [31:0] c0, c1, c2, c3,
                         input logic [31:0] e0, e1, e2, e3);
    sums    = '{s0, s1, s2, s3};
    carries = '{c0, c1, c2, c3};
    exp_d   = '{e0, e1, e2, e3};
  endtask

  // Pulse start, check the clear/latency sequence, and scramble inputs after capture.
  task automatic do_start(input string tag);
    in_sum   = {sums[3], sums[2], sums[1], sums[0]};
    in_carry = {carries[3], carries[2], carries[1], carries[0]};
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_clc_hi"}, clc, 1);
    check({tag, "_valid_lo"}, out_valid, 0);
    check({tag, "_busy"}, busy, 1);
    in_sum   = ~in_sum;
    in_carry = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    tick();
    check({tag, "_clc_lo"}, clc, 0);
    check({tag, "_valid_hi"}, out_valid, 1);
    check({tag, "_row0"}, out_row, 0);
  endtask

  // Collect four beats; optionally stall with ready pattern 1,0,0,1 and hold start high.
  task automatic drain(input string tag, input bit toggle, input bit poke);
    int   n = 0;
    bit   stalled = 1'b0;
    bit   pat [4];
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hl;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      start     = poke;
      if (poke) check({tag, "_no_clc"}, clc, 0);
      if (out_valid) begin
        if (stalled) begin
          check({tag, "_hold_data"}, out_data, hd);
          check({tag, "_hold_row"}, out_row, hr);
          check({tag, "_hold_last"}, out_last, hl);
        end
        if (out_ready) begin
          check({tag, "_data"}, out_data, exp_d[n]);
          check({tag, "_row"}, out_row, n[1:0]);
          check({tag, "_last"}, out_last, (n == 3));
          n++;
          stalled = 1'b0;
        end else if (!stalled) begin
          hd = out_data;
          hr = out_row;
          hl = out_last;
          stalled = 1'b1;
        end
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_beats"}, n, 4);
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_last"}, out_last, 0);
    check({tag, "_end_clc"}, clc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clc", clc, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    rst = 1'b0;
    tick();

    // Continuous ready: one beat per cycle.
    set_vec(10, 20, 30, 40, 1, 2, 3, 4, 11, 22, 33, 44);
    out_ready = 1'b1;
    do_start("basic");
    drain("basic", 1'b0, 1'b0);

    // Stalls with start held high throughout; restart on the very next cycle.
    do_start("stall");
    drain("stall", 1'b1, 1'b1);
    set_vec(32'h100, 32'h200, 32'h300, 32'h400, 5, 6, 7, 8,
            32'h105, 32'h206, 32'h307, 32'h408);
    do_start("restart");
    drain("restart", 1'b0, 1'b0);

    // Modulo wrap, and the clamp cases when saturation is enabled.
`ifdef OPT1_DRAIN_SAT_EN
    set_vec(32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_0000, 32'h7,
            32'h1, 32'h0, 32'h0, 32'h8,
            32'h0, 32'h0000_7FFF, 32'hFFFF_8000, 32'hF);
`else
    set_vec(32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_0000, 32'h7,
            32'h1, 32'h0, 32'h0, 32'h8,
            32'h0, 32'h0001_0000, 32'hFFFF_0000, 32'hF);
`endif
    do_start("wrap");
    drain("wrap", 1'b0, 1'b0);

    // Reset after the second beat is accepted.
    set_vec(10, 20, 30, 40, 1, 2, 3, 4, 11, 22, 33, 44);
    do_start("rmid");
    out_ready = 1'b1;
    tick();
    tick();
    check("rmid_row2", out_row, 2);
    #2 rst = 1'b1;
    #1;
    check("rmid_valid", out_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_clc", clc, 0);
    check("rmid_data", out_data, 0);
    check("rmid_row", out_row, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
    end

    do_start("recover");
    drain("recover", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
